// File: rtl/adc_sample_averager_if.sv
// Controller and XADC side signals of the ADC sample averager, grouped as one bus.
interface adc_sample_averager_if #(
    parameter int unsigned NB_DATA = 12,
    parameter int unsigned NB_ADC  = 16
) ();

    logic               i_trigger;
    logic               o_convst;
    logic               i_eoc;
    logic [NB_ADC-1:0]  i_adc_data;
    logic [NB_DATA-1:0] o_value;
    logic               o_done;
    logic               o_busy;
    logic               o_timeout_err;
    logic               o_overrun_err;

    // Averager side
    modport slave (
        input  i_trigger, i_eoc, i_adc_data,
        output o_convst, o_value, o_done, o_busy, o_timeout_err, o_overrun_err
    );

    // Controller / XADC side
    modport master (
        output i_trigger, i_eoc, i_adc_data,
        input  o_convst, o_value, o_done, o_busy, o_timeout_err, o_overrun_err
    );

endinterface

// File: rtl/adc_sample_averager.sv
// Runs 2^N_AVG_LOG2 XADC conversions per trigger and returns the floor of their mean.
module adc_sample_averager #(
    parameter int unsigned NB_DATA       = 12,
    parameter int unsigned NB_ADC        = 16,
    parameter int unsigned N_AVG_LOG2    = 2,
    parameter int unsigned CONVST_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1023
) (
    input  logic                  clk,
    input  logic                  i_rst,
    adc_sample_averager_if.slave  bus
);

    localparam int unsigned ACC_W     = NB_DATA + N_AVG_LOG2;
    localparam int unsigned N_SAMPLES = 1 << N_AVG_LOG2;
    localparam int unsigned SCNT_W    = N_AVG_LOG2 + 1;
    localparam int unsigned CCNT_W    = $clog2(CONVST_CYCLES + 1);
    localparam int unsigned TCNT_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVST,
        ST_WAIT_EOC,
        ST_ACCUM,
        ST_DONE
    } state_e;

    state_e             state_q,       state_d;
    logic [CCNT_W-1:0]  conv_cnt_q,    conv_cnt_d;
    logic [TCNT_W-1:0]  tmo_cnt_q,     tmo_cnt_d;
    logic [SCNT_W-1:0]  smp_cnt_q,     smp_cnt_d;
    logic [ACC_W-1:0]   acc_q,         acc_d;
    logic [NB_DATA-1:0] sample_q,      sample_d;
    logic [NB_DATA-1:0] value_q,       value_d;
    logic               convst_q,      convst_d;
    logic               done_q,        done_d;
    logic               busy_q,        busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic               overrun_err_q, overrun_err_d;
    logic [ACC_W-1:0]   acc_sum_c;
    logic               unused_adc_lsbs_c;

    // Only the MSBs of the XADC word carry the sample
    assign unused_adc_lsbs_c = ^bus.i_adc_data[NB_ADC-NB_DATA-1:0];

    // Next-state, datapath and next-output computation
    always_comb begin
        state_d       = state_q;
        conv_cnt_d    = conv_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        smp_cnt_d     = smp_cnt_q;
        acc_d         = acc_q;
        sample_d      = sample_q;
        value_d       = value_q;
        timeout_err_d = timeout_err_q;
        overrun_err_d = overrun_err_q;
        acc_sum_c     = acc_q + ACC_W'(sample_q);

        // A trigger outside IDLE is dropped and flagged
        if (state_q != ST_IDLE && bus.i_trigger) begin
            overrun_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_trigger) begin
                    acc_d      = '0;
                    smp_cnt_d  = '0;
                    conv_cnt_d = '0;
                    state_d    = ST_CONVST;
                end
            end
            ST_CONVST: begin
                if (conv_cnt_q == CCNT_W'(CONVST_CYCLES - 1)) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_EOC;
                end else begin
                    conv_cnt_d = conv_cnt_q + CCNT_W'(1);
                end
            end
            ST_WAIT_EOC: begin
                if (bus.i_eoc) begin
                    sample_d = bus.i_adc_data[NB_ADC-1 -: NB_DATA];
                    state_d  = ST_ACCUM;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TCNT_W'(1);
                    if (tmo_cnt_q == TCNT_W'(TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        value_d       = '1;
                        state_d       = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                acc_d     = acc_sum_c;
                smp_cnt_d = smp_cnt_q + SCNT_W'(1);
                if (smp_cnt_d == SCNT_W'(N_SAMPLES)) begin
                    value_d = NB_DATA'(acc_sum_c >> N_AVG_LOG2);
                    state_d = ST_DONE;
                end else begin
                    conv_cnt_d = '0;
                    state_d    = ST_CONVST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        convst_d = (state_d == ST_CONVST);
        done_d   = (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            conv_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            smp_cnt_q     <= '0;
            acc_q         <= '0;
            sample_q      <= '0;
            value_q       <= '0;
            convst_q      <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            conv_cnt_q    <= conv_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            smp_cnt_q     <= smp_cnt_d;
            acc_q         <= acc_d;
            sample_q      <= sample_d;
            value_q       <= value_d;
            convst_q      <= convst_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign bus.o_convst      = convst_q;
    assign bus.o_value       = value_q;
    assign bus.o_done        = done_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_timeout_err = timeout_err_q;
    assign bus.o_overrun_err = overrun_err_q;

endmodule
